// File: rtl/serial_approx_add_ctrl.sv
// Bit-serial adder sequencer, LSB-first, one full-adder cell per clock.
// The low k bits use lower-part-OR approximation (k = min(approx_bits, WIDTH)).
// Ports:
//   clk, rst_n
//   in_valid/in_ready   : operand handshake (op_a, op_b, cin, approx_bits)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high while bits are being processed
module serial_approx_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic [AW-1:0]    approx_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] KMAX = AW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [AW-1:0]    k_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [AW-1:0] k_in;
  logic          approx;
  logic          a_i;
  logic          b_i;
  logic          s_bit;
  logic          c_nxt;

  assign k_in = (approx_bits > KMAX) ? KMAX : approx_bits;
  assign cout = carry;

  always_comb begin
    a_i    = a_sh[0];
    b_i    = b_sh[0];
    approx = (AW'(cnt) < k_q);
    s_bit  = a_i ^ b_i ^ carry;
    c_nxt  = (a_i & b_i) | (a_i & carry) | (b_i & carry);
    // LOA bits ignore the incoming carry; the last
    // approximate bit's AND seeds the exact part.
    if (approx) begin
      s_bit = a_i | b_i;
      c_nxt = a_i & b_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      k_q       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= op_a;
            b_sh     <= op_b;
            k_q      <= k_in;
            carry    <= (k_in == '0) ? cin : 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum   <= {s_bit, sum[WIDTH-1:1]};
          carry <= c_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_approx_add_ctrl.sv
// Directed-vector bench for serial_approx_add_ctrl.
// Checks reset state, latency, exact/LOA sums, clamp, backpressure, reset.
module tb_serial_approx_add_ctrl;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          cin;
  logic [AW-1:0] approx_bits;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  serial_approx_add_ctrl #(.WIDTH(W), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .approx_bits (approx_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction, wait for the result, check it,
  // and optionally consume it.
  task automatic run_txn(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic ci,
                         input logic [AW-1:0] ab,
                         input logic [W-1:0] e_sum,
                         input logic e_cout,
                         input bit consume);
    int n;
    bit seen;
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    op_a        = a;
    op_b        = b;
    cin         = ci;
    approx_bits = ab;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    seen = 0;
    n    = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        seen = 1;
        n    = i;
        break;
      end
    end
    if (!seen) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, ".lat"}, 32'(n), 32'(W));
      check({tag, ".sum"}, 32'(sum), 32'(e_sum));
      check({tag, ".cout"}, 32'(cout), 32'(e_cout));
      check({tag, ".busy0"}, 32'(busy), 32'd0);
      if (consume) begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".ov0"}, 32'(out_valid), 32'd0);
        check({tag, ".rdy1"}, 32'(in_ready), 32'd1);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    cin         = 1'b0;
    approx_bits = '0;
    #12;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_txn("exact_ff_01", 8'hFF, 8'h01, 1'b0, 4'd0, 8'h00, 1'b1, 1);
    run_txn("exact_cin", 8'h7F, 8'h80, 1'b1, 4'd0, 8'h00, 1'b1, 1);
    run_txn("loa4_a", 8'h18, 8'h08, 1'b1, 4'd4, 8'h28, 1'b0, 1);
    run_txn("loa4_b", 8'h0F, 8'h01, 1'b0, 4'd4, 8'h0F, 1'b0, 1);
    run_txn("clamp15", 8'h80, 8'h80, 1'b0, 4'd15, 8'h80, 1'b1, 1);
    run_txn("loa8", 8'hA5, 8'h5A, 1'b1, 4'd8, 8'hFF, 1'b0, 1);
    run_txn("loa1", 8'h03, 8'h01, 1'b1, 4'd1, 8'h05, 1'b0, 1);
    run_txn("exact_mix", 8'h3C, 8'h47, 1'b1, 4'd0, 8'h84, 1'b0, 1);

    // Backpressure: stay in DONE while another set is offered.
    run_txn("bp", 8'h12, 8'h34, 1'b0, 4'd0, 8'h46, 1'b0, 0);
    op_a        = 8'hFF;
    op_b        = 8'hFF;
    cin         = 1'b1;
    approx_bits = 4'd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      check("bp.ov", 32'(out_valid), 32'd1);
      check("bp.rdy", 32'(in_ready), 32'd0);
      check("bp.sum", 32'(sum), 32'h46);
      check("bp.cout", 32'(cout), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.ov0", 32'(out_valid), 32'd0);
    check("bp.rdy1", 32'(in_ready), 32'd1);
    run_txn("bp_next", 8'hC8, 8'h64, 1'b0, 4'd0, 8'h2C, 1'b1, 1);

    // Reset while bit 3 is being processed.
    op_a        = 8'hF0;
    op_b        = 8'h0F;
    cin         = 1'b0;
    approx_bits = 4'd0;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.ov", 32'(out_valid), 32'd0);
    check("mid.busy0", 32'(busy), 32'd0);
    check("mid.rdy", 32'(in_ready), 32'd1);
    check("mid.sum", 32'(sum), 32'd0);
    check("mid.cout", 32'(cout), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_txn("post_rst", 8'h55, 8'hAA, 1'b0, 4'd0, 8'hFF, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
